// File: rtl/mac_conv_sequencer.sv
// Sequences one MAC unit through kernel-memory loads and K x K two-row convolution jobs.
// Optional feature: define MAC_SEQ_RELU_EN to clamp each signed 16-bit result half at zero.
module mac_conv_sequencer #(
  parameter int KMAX = 5,
  parameter int AW   = 12
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ld_start,
  input  logic [AW-1:0] i_ld_base,
  input  logic [AW-1:0] i_ld_len,
  input  logic          i_ld_valid,
  input  logic [15:0]   i_ld_data,
  output logic          o_ld_ready,
  output logic          o_ld_done,
  input  logic          i_job_start,
  input  logic [2:0]    i_cfg_ksize,
  input  logic [AW-1:0] i_cfg_kbase,
  input  logic [AW-1:0] i_cfg_bias_addr,
  output logic          o_busy,
  output logic          o_cfg_err,
  output logic [2:0]    o_px_row,
  output logic [2:0]    o_px_col,
  output logic [AW-1:0] o_kern_addr,
  output logic [15:0]   o_kern_give_data,
  output logic          o_kern_input_mode,
  output logic          o_kern_accept,
  output logic          o_init_buffer,
  output logic          o_mac_start,
  output logic          o_mac_start_with_bias,
  output logic          o_conv_row,
  input  logic          i_mac_work,
  input  logic [31:0]   i_result_px,
  output logic          o_res_valid,
  output logic [31:0]   o_res_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_ENTER,
    S_LD_STREAM,
    S_LD_EXIT,
    S_BIAS_ISSUE,
    S_OP_ISSUE,
    S_OP_WAIT,
    S_RESULT
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;

  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_ld_base;
  logic [AW-1:0] r_ld_len;
  logic [2:0]    r_k;
  logic [AW-1:0] r_kbase;
  logic [AW-1:0] r_bias_addr;
  logic [4:0]    r_tap;
  logic [4:0]    r_last_tap;
  logic [2:0]    r_kx;
  logic [2:0]    r_ky;
  logic          r_row;
  logic          r_bias_phase;
  logic [31:0]   r_res_data;

  logic          w_job_ok;
  logic          w_ld_last;
  logic          w_last_op;
  logic [4:0]    w_kk;
  logic [AW-1:0] w_op_addr;
  logic [31:0]   w_res_next;

  assign w_job_ok  = (i_cfg_ksize != 3'd0) && (int'(i_cfg_ksize) <= KMAX);
  assign w_ld_last = (r_cnt == (r_ld_len - AW'(1)));
  assign w_last_op = (r_tap == r_last_tap) && r_row;
  assign w_kk      = {2'b00, i_cfg_ksize} * {2'b00, i_cfg_ksize};
  assign w_op_addr = r_kbase + AW'(r_tap);

`ifdef MAC_SEQ_RELU_EN
  assign w_res_next = {(i_result_px[31] ? 16'h0000 : i_result_px[31:16]),
                       (i_result_px[15] ? 16'h0000 : i_result_px[15:0])};
`else
  assign w_res_next = i_result_px;
`endif

  assign o_res_data = r_res_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx            = r_state;
    o_ld_ready            = 1'b0;
    o_ld_done             = 1'b0;
    o_busy                = (r_state != S_IDLE);
    o_cfg_err             = 1'b0;
    o_px_row              = 3'd0;
    o_px_col              = 3'd0;
    o_kern_addr           = '0;
    o_kern_give_data      = 16'h0000;
    o_kern_input_mode     = 1'b0;
    o_kern_accept         = 1'b0;
    o_init_buffer         = 1'b0;
    o_mac_start           = 1'b0;
    o_mac_start_with_bias = 1'b0;
    o_conv_row            = 1'b0;
    o_res_valid           = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A load request wins over a simultaneous job request
        if (i_ld_start) begin
          w_state_nx = (i_ld_len == '0) ? S_LD_EXIT : S_LD_ENTER;
        end else if (i_job_start) begin
          if (w_job_ok) w_state_nx = S_BIAS_ISSUE;
          else          o_cfg_err  = 1'b1;
        end
      end
      S_LD_ENTER: begin
        o_kern_input_mode = 1'b1;
        w_state_nx        = S_LD_STREAM;
      end
      S_LD_STREAM: begin
        o_kern_input_mode = 1'b1;
        o_ld_ready        = 1'b1;
        o_kern_accept     = i_ld_valid;
        o_kern_addr       = r_ld_base + r_cnt;
        o_kern_give_data  = i_ld_data;
        if (i_ld_valid && w_ld_last) w_state_nx = S_LD_EXIT;
      end
      S_LD_EXIT: begin
        if (!i_mac_work) begin
          o_ld_done  = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      S_BIAS_ISSUE: begin
        o_kern_addr   = r_bias_addr;
        o_init_buffer = 1'b1;
        w_state_nx    = S_OP_WAIT;
      end
      S_OP_ISSUE: begin
        o_kern_addr           = w_op_addr;
        o_px_row              = r_ky + {2'b00, r_row};
        o_px_col              = r_kx;
        o_conv_row            = r_row;
        o_mac_start_with_bias = (r_tap == 5'd0) && !r_row;
        o_mac_start           = !((r_tap == 5'd0) && !r_row);
        w_state_nx            = S_OP_WAIT;
      end
      S_OP_WAIT: begin
        if (r_bias_phase) begin
          o_kern_addr = r_bias_addr;
        end else begin
          o_kern_addr = w_op_addr;
          o_px_row    = r_ky + {2'b00, r_row};
          o_px_col    = r_kx;
          o_conv_row  = r_row;
        end
        // A MAC that skips a zero weight never raises work, so a low first cycle is a completion
        if (!i_mac_work) begin
          if (!r_bias_phase && w_last_op) w_state_nx = S_RESULT;
          else                            w_state_nx = S_OP_ISSUE;
        end
      end
      S_RESULT: begin
        o_res_valid = 1'b1;
        w_state_nx  = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_ld_base    <= '0;
      r_ld_len     <= '0;
      r_k          <= 3'd0;
      r_kbase      <= '0;
      r_bias_addr  <= '0;
      r_tap        <= 5'd0;
      r_last_tap   <= 5'd0;
      r_kx         <= 3'd0;
      r_ky         <= 3'd0;
      r_row        <= 1'b0;
      r_bias_phase <= 1'b0;
      r_res_data   <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_ld_start) begin
            r_ld_base <= i_ld_base;
            r_ld_len  <= i_ld_len;
          end else if (i_job_start && w_job_ok) begin
            r_k          <= i_cfg_ksize;
            r_kbase      <= i_cfg_kbase;
            r_bias_addr  <= i_cfg_bias_addr;
            r_last_tap   <= w_kk - 5'd1;
            r_tap        <= 5'd0;
            r_kx         <= 3'd0;
            r_ky         <= 3'd0;
            r_row        <= 1'b0;
            r_bias_phase <= 1'b1;
          end
        end
        S_LD_STREAM: begin
          if (i_ld_valid) r_cnt <= r_cnt + AW'(1);
        end
        S_OP_WAIT: begin
          // Each tap runs row 0 then row 1 before the kernel position advances
          if (!i_mac_work) begin
            if (r_bias_phase) begin
              r_bias_phase <= 1'b0;
            end else if (w_last_op) begin
              r_res_data <= w_res_next;
            end else if (!r_row) begin
              r_row <= 1'b1;
            end else begin
              r_row <= 1'b0;
              r_tap <= r_tap + 5'd1;
              if (r_kx == (r_k - 3'd1)) begin
                r_kx <= 3'd0;
                r_ky <= r_ky + 3'd1;
              end else begin
                r_kx <= r_kx + 3'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_conv_sequencer.sv
// Scoreboard bench for mac_conv_sequencer with a small behavioural MAC model.
// Covers loads, conv jobs, zero-skip taps, rejected configs, arbitration, mid-job reset and MAC_SEQ_RELU_EN.
module tb_mac_conv_sequencer;

  localparam int AW = 12;
  localparam int EV_LD = 0;
  localparam int EV_RES = 1;
  localparam int EV_ERR = 2;

  logic          clk;
  logic          rst_n;
  logic          ldStart;
  logic [AW-1:0] ldBase;
  logic [AW-1:0] ldLen;
  logic          ldValid;
  logic [15:0]   ldData;
  logic          ldReady;
  logic          ldDone;
  logic          jobStart;
  logic [2:0]    cfgKsize;
  logic [AW-1:0] cfgKbase;
  logic [AW-1:0] cfgBiasAddr;
  logic          busy;
  logic          cfgErr;
  logic [2:0]    pxRow;
  logic [2:0]    pxCol;
  logic [AW-1:0] kernAddr;
  logic [15:0]   kernGiveData;
  logic          kernInputMode;
  logic          kernAccept;
  logic          initBuffer;
  logic          macStart;
  logic          macStartWithBias;
  logic          convRow;
  logic          macWork;
  logic [31:0]   resultPx;
  logic          resValid;
  logic [31:0]   resData;

  mac_conv_sequencer #(.KMAX(5), .AW(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ld_start(ldStart), .i_ld_base(ldBase), .i_ld_len(ldLen),
    .i_ld_valid(ldValid), .i_ld_data(ldData), .o_ld_ready(ldReady), .o_ld_done(ldDone),
    .i_job_start(jobStart), .i_cfg_ksize(cfgKsize), .i_cfg_kbase(cfgKbase),
    .i_cfg_bias_addr(cfgBiasAddr), .o_busy(busy), .o_cfg_err(cfgErr),
    .o_px_row(pxRow), .o_px_col(pxCol), .o_kern_addr(kernAddr),
    .o_kern_give_data(kernGiveData), .o_kern_input_mode(kernInputMode),
    .o_kern_accept(kernAccept), .o_init_buffer(initBuffer), .o_mac_start(macStart),
    .o_mac_start_with_bias(macStartWithBias), .o_conv_row(convRow),
    .i_mac_work(macWork), .i_result_px(resultPx),
    .o_res_valid(resValid), .o_res_data(resData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: pixel value is always 1, zero weights are skipped without raising work
  logic [15:0] macMem [0:4095];
  logic [15:0] acc0, acc1;
  int          workCnt;
  assign macWork  = (workCnt != 0);
  assign resultPx = {acc0, acc1};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc0 <= 16'h0; acc1 <= 16'h0; workCnt <= 0;
    end else begin
      if (workCnt != 0) workCnt <= workCnt - 1;
      if (kernInputMode && kernAccept) begin
        macMem[kernAddr] <= kernGiveData;
        workCnt <= 2;
      end
      if (initBuffer) begin
        acc0 <= macMem[kernAddr]; acc1 <= macMem[kernAddr];
      end
      if ((macStart || macStartWithBias) && macMem[kernAddr] != 16'h0) begin
        if (convRow) acc1 <= acc1 + macMem[kernAddr];
        else         acc0 <= acc0 + macMem[kernAddr];
        workCnt <= 3;
      end
    end
  end

  typedef struct { int kind; logic [31:0] data; } exp_t;
  exp_t expQ[$];

  int testsRun = 0;
  int testsFailed = 0;
  int initCnt, withBiasCnt, macStartCnt, acceptCnt, modeHighCnt, busyHighCnt;
  int ldDoneCnt, resValidCnt, errCnt;
  int opIdx = 0;
  int curK = 1;
  logic [AW-1:0] curKbase = '0;
  int cyc = 0;
  int prevCyc = 0;
  logic [AW-1:0] prevAddr = '0;
  bit prevValid = 1'b0;
  int skipGaps[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic popExpect(input int kind, input logic [31:0] data);
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput("unexpectedEvent", kind, 99);
    end else begin
      e = expQ.pop_front();
      checkOutput("eventKind", kind, e.kind);
      checkOutput("eventData", data, e.data);
    end
  endtask

  task automatic pushExpect(input int kind, input logic [31:0] data);
    exp_t e;
    e.kind = kind; e.data = data;
    expQ.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts strobes, checks per-op addressing and pops the scoreboard on every event
  always @(negedge clk) begin
    if (rst_n) begin
      int strobes;
      int tap;
      strobes = int'(initBuffer) + int'(macStart) + int'(macStartWithBias);
      if (strobes != 0) checkOutput("strobeOnehot", strobes, 1);
      if (initBuffer) begin initCnt++; opIdx = 0; prevValid = 1'b0; end
      if (macStartWithBias) withBiasCnt++;
      if (macStart) macStartCnt++;
      if (kernAccept) acceptCnt++;
      if (kernInputMode) modeHighCnt++;
      if (busy) busyHighCnt++;
      if (macStart || macStartWithBias) begin
        tap = opIdx / 2;
        checkOutput("convRow", convRow, opIdx % 2);
        checkOutput("kernAddr", kernAddr, curKbase + 12'(tap));
        checkOutput("withBiasOp0", macStartWithBias, (opIdx == 0));
        checkOutput("pxCol", pxCol, tap % curK);
        checkOutput("pxRow", pxRow, (tap / curK) + (opIdx % 2));
        if (prevValid && prevAddr == 12'h014) skipGaps.push_back(cyc - prevCyc);
        prevAddr = kernAddr; prevCyc = cyc; prevValid = 1'b1;
        opIdx++;
      end
      if (ldDone)   begin ldDoneCnt++;   popExpect(EV_LD, 32'h0);      end
      if (resValid) begin resValidCnt++; popExpect(EV_RES, resData);   end
      if (cfgErr)   begin errCnt++;      popExpect(EV_ERR, 32'h0);     end
    end
  end

  task automatic clearCounts();
    initCnt = 0; withBiasCnt = 0; macStartCnt = 0; acceptCnt = 0; modeHighCnt = 0;
    busyHighCnt = 0; ldDoneCnt = 0; resValidCnt = 0; errCnt = 0;
  endtask

  task automatic applyStimulus(input bit isLoad, input bit isJob, input logic [AW-1:0] base,
                               input logic [AW-1:0] len, input logic [2:0] k,
                               input logic [AW-1:0] kbase, input logic [AW-1:0] bias);
    @(posedge clk); #1;
    ldStart = isLoad; ldBase = base; ldLen = len;
    jobStart = isJob; cfgKsize = k; cfgKbase = kbase; cfgBiasAddr = bias;
    @(posedge clk); #1;
    ldStart = 1'b0; jobStart = 1'b0;
  endtask

  task automatic streamWord(input logic [15:0] d, input bit gap);
    int n;
    if (gap) @(posedge clk);
    @(posedge clk); #1;
    ldValid = 1'b1; ldData = d; n = 0;
    while (!ldReady && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) checkOutput("streamReadyTimeout", n, 0);
    @(posedge clk); #1;
    ldValid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin @(negedge clk); n++; end
    checkOutput("drainTimeout", expQ.size(), 0);
    expQ.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic runJob(input logic [2:0] k, input logic [AW-1:0] kbase,
                        input logic [AW-1:0] bias, input logic [31:0] expRes);
    curK = int'(k); curKbase = kbase;
    pushExpect(EV_RES, expRes);
    applyStimulus(1'b0, 1'b1, '0, '0, k, kbase, bias);
    waitDrain(400);
  endtask

  initial begin
    logic [31:0] reluExp;
    int n;
    for (int i = 0; i < 4096; i++) macMem[i] = 16'h0;
    rst_n = 1'b0; ldStart = 1'b0; ldBase = '0; ldLen = '0; ldValid = 1'b0; ldData = 16'h0;
    jobStart = 1'b0; cfgKsize = 3'd0; cfgKbase = '0; cfgBiasAddr = '0;
    clearCounts();
    #3;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetResData", resData, 0);
    checkOutput("resetStrobes", {initBuffer, macStart, macStartWithBias, kernInputMode, resValid}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] load 9 words at 0x010 with gaps");
    clearCounts();
    pushExpect(EV_LD, 32'h0);
    applyStimulus(1'b1, 1'b0, 12'h010, 12'd9, 3'd0, '0, '0);
    for (int i = 1; i <= 9; i++) streamWord(16'(i), (i % 2) == 0);
    waitDrain(100);
    checkOutput("loadAccepts", acceptCnt, 9);
    checkOutput("loadDoneOnce", ldDoneCnt, 1);
    for (int i = 0; i < 9; i++) checkOutput("loadMem", macMem[12'h010 + 12'(i)], i + 1);

    pushExpect(EV_LD, 32'h0);
    applyStimulus(1'b1, 1'b0, 12'h000, 12'd1, 3'd0, '0, '0);
    streamWord(16'd5, 1'b0);
    waitDrain(100);

    $display("[TB] K=3 job, bias 5, taps 1..9");
    clearCounts();
    runJob(3'd3, 12'h010, 12'h000, 32'h0032_0032);
    checkOutput("jobInitCnt", initCnt, 1);
    checkOutput("jobWithBiasCnt", withBiasCnt, 1);
    checkOutput("jobMacStartCnt", macStartCnt, 17);
    checkOutput("jobResValidCnt", resValidCnt, 1);
    checkOutput("jobModeLow", modeHighCnt, 0);

    $display("[TB] K=3 job with zero weight at tap 4");
    pushExpect(EV_LD, 32'h0);
    applyStimulus(1'b1, 1'b0, 12'h014, 12'd1, 3'd0, '0, '0);
    streamWord(16'd0, 1'b0);
    waitDrain(100);
    skipGaps.delete();
    runJob(3'd3, 12'h010, 12'h000, 32'h002D_002D);
    checkOutput("skipGapCount", skipGaps.size(), 2);
    for (int i = 0; i < skipGaps.size(); i++) checkOutput("skipGapCycles", skipGaps[i], 2);

    $display("[TB] invalid K rejection");
    clearCounts();
    pushExpect(EV_ERR, 32'h0);
    applyStimulus(1'b0, 1'b1, '0, '0, 3'd0, 12'h010, 12'h000);
    pushExpect(EV_ERR, 32'h0);
    applyStimulus(1'b0, 1'b1, '0, '0, 3'd6, 12'h010, 12'h000);
    waitDrain(20);
    checkOutput("errCnt", errCnt, 2);
    checkOutput("errBusyLow", busyHighCnt, 0);
    checkOutput("errNoStrobes", initCnt + withBiasCnt + macStartCnt, 0);

    $display("[TB] load beats job, job ignored while busy");
    clearCounts();
    pushExpect(EV_LD, 32'h0);
    applyStimulus(1'b1, 1'b1, 12'h030, 12'd2, 3'd3, 12'h010, 12'h000);
    jobStart = 1'b1;
    streamWord(16'h1234, 1'b0);
    streamWord(16'h5678, 1'b1);
    jobStart = 1'b0;
    waitDrain(100);
    checkOutput("arbMem0", macMem[12'h030], 32'h1234);
    checkOutput("arbMem1", macMem[12'h031], 32'h5678);
    checkOutput("arbNoJob", initCnt, 0);
    checkOutput("arbNoErr", errCnt, 0);
    checkOutput("arbIdle", busy, 0);

    clearCounts();
    pushExpect(EV_LD, 32'h0);
    applyStimulus(1'b1, 1'b0, 12'h040, 12'd0, 3'd0, '0, '0);
    checkOutput("len0DoneNext", ldDone, 1);
    waitDrain(20);
    checkOutput("len0ModeLow", modeHighCnt, 0);
    checkOutput("len0NoAccept", acceptCnt, 0);

    $display("[TB] reset mid OP_WAIT then rerun");
    clearCounts();
    curK = 3; curKbase = 12'h010;
    applyStimulus(1'b0, 1'b1, '0, '0, 3'd3, 12'h010, 12'h000);
    n = 0;
    while (opIdx < 5 && n < 300) begin @(negedge clk); n++; end
    checkOutput("midJobReached", (opIdx >= 5), 1);
    @(posedge clk); #2;
    checkOutput("preResetBusy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncBusy", busy, 0);
    checkOutput("asyncKernAddr", kernAddr, 0);
    checkOutput("asyncResData", resData, 0);
    checkOutput("asyncCtl", {initBuffer, macStart, macStartWithBias, convRow, pxRow, pxCol,
                             kernInputMode, kernAccept, ldReady, ldDone, cfgErr, resValid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("abortNoRes", resValidCnt, 0);
    runJob(3'd3, 12'h010, 12'h000, 32'h002D_002D);
    checkOutput("rerunResValidCnt", resValidCnt, 1);

    $display("[TB] K=1 job with negative accumulators");
    pushExpect(EV_LD, 32'h0);
    applyStimulus(1'b1, 1'b0, 12'h020, 12'd2, 3'd0, '0, '0);
    streamWord(16'h0002, 1'b0);
    streamWord(16'hFFF0, 1'b0);
    waitDrain(100);
    clearCounts();
`ifdef MAC_SEQ_RELU_EN
    reluExp = 32'h0000_0000;
`else
    reluExp = 32'hFFF2_FFF2;
`endif
    runJob(3'd1, 12'h020, 12'h021, reluExp);
    checkOutput("k1WithBias", withBiasCnt, 1);
    checkOutput("k1MacStart", macStartCnt, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got 1, expected 0");
    $fatal(1, "[TB] timeout");
  end

endmodule
